// File: rtl/wahb_pkg.sv
// Shared AHB encodings and bridge FSM states for the Wishbone-slave / AHB-master bridge.
// Used by ahbmas_wbslv_bridge and wahb_sel_decode.
package wahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/wahb_sel_decode.sv
// Combinational byte-select decoder: maps a Wishbone sel vector to {legal, hsize, lane offset}.
// Legal selects are aligned, contiguous, power-of-two-sized groups of byte lanes.
module wahb_sel_decode
  import wahb_pkg::*;
#(
  parameter int SWIDTH = 4,
  parameter int OW     = 2
) (
  input  logic [SWIDTH-1:0] sel_i,
  output logic              legal_o,
  output logic [2:0]        hsize_o,
  output logic [OW-1:0]     offset_o
);

  function automatic logic [SWIDTH-1:0] lane_mask(input int k, input int p);
    logic [SWIDTH-1:0] ones;
    ones = '1;
    return (ones >> (SWIDTH - (1 << k))) << p;
  endfunction

  // Try every aligned group of 2^k lanes; at most one mask can match.
  always_comb begin
    legal_o  = 1'b0;
    hsize_o  = HSIZE_WORD;
    offset_o = '0;
    for (int k = 0; k <= OW; k++) begin
      for (int p = 0; p < SWIDTH; p++) begin
        if (((p % (1 << k)) == 0) && (sel_i == lane_mask(k, p))) begin
          legal_o  = 1'b1;
          hsize_o  = 3'(k);
          offset_o = OW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/ahbmas_wbslv_bridge.sv
// Wishbone slave to AHB master bridge: one SINGLE transfer per Wishbone cycle, registered outputs.
// Define WAHB_RETRY_EN to re-issue on RETRY/SPLIT (up to MAX_RETRY times); otherwise they act as ERROR.
module ahbmas_wbslv_bridge
  import wahb_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_RETRY = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [DWIDTH/8-1:0] sel_i,
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [DWIDTH-1:0]   data_i,
  output logic [DWIDTH-1:0]   data_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [AWIDTH-1:0]   haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [DWIDTH-1:0]   hwdata,
  input  logic [DWIDTH-1:0]   hrdata,
  input  logic                hready,
  input  logic [1:0]          hresp
);

  localparam int SWIDTH = DWIDTH / 8;
  localparam int OW     = $clog2(SWIDTH);
  localparam logic [AWIDTH-1:0] LANE_MASK = AWIDTH'(SWIDTH - 1);

  state_e              state_q;
  logic [1:0]          htrans_q;
  logic [AWIDTH-1:0]   haddr_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [DWIDTH-1:0]   hwdata_q;
  logic [DWIDTH-1:0]   data_q;
  logic                ack_q;
  logic                err_q;
  logic                abort_q;

  logic                dec_legal;
  logic [2:0]          dec_hsize;
  logic [OW-1:0]       dec_offset;

`ifdef WAHB_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt_q;
  logic          retry_resp;
  assign retry_resp = (hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT);
`endif

  wahb_sel_decode #(
    .SWIDTH (SWIDTH),
    .OW     (OW)
  ) u_sel_decode (
    .sel_i    (sel_i),
    .legal_o  (dec_legal),
    .hsize_o  (dec_hsize),
    .offset_o (dec_offset)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_WORD;
      hwdata_q <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
`ifdef WAHB_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (cyc_i && stb_i && !ack_q && !err_q) begin
            if (dec_legal) begin
              // Low address bits come from the lowest selected lane, not from addr_i.
              haddr_q  <= (addr_i & ~LANE_MASK) | AWIDTH'(dec_offset);
              hwrite_q <= we_i;
              hsize_q  <= dec_hsize;
              hwdata_q <= data_i;
              htrans_q <= HTRANS_NONSEQ;
              state_q  <= ST_ADDR;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (!cyc_i) abort_q <= 1'b1;
          if (hready) begin
            htrans_q <= HTRANS_IDLE;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!cyc_i) abort_q <= 1'b1;
          // Only hready=1 cycles end the data phase, so the first half of a two-cycle response is ignored.
          if (hready) begin
            if (abort_q || !cyc_i) begin
              state_q <= ST_IDLE;
`ifdef WAHB_RETRY_EN
              retry_cnt_q <= '0;
`endif
            end else if (hresp == HRESP_OKAY) begin
              if (!hwrite_q) data_q <= hrdata;
              ack_q   <= 1'b1;
              state_q <= ST_RESP;
            end
`ifdef WAHB_RETRY_EN
            else if (retry_resp && (retry_cnt_q < RW'(MAX_RETRY))) begin
              retry_cnt_q <= retry_cnt_q + 1'b1;
              htrans_q    <= HTRANS_NONSEQ;
              state_q     <= ST_ADDR;
            end
`endif
            else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
`ifdef WAHB_RETRY_EN
          retry_cnt_q <= '0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign haddr  = haddr_q;
  assign htrans = htrans_q;
  assign hwrite = hwrite_q;
  assign hsize  = hsize_q;
  assign hburst = HBURST_SINGLE;
  assign hwdata = hwdata_q;

endmodule
